// File: rtl/cache_sim_pkg.sv
// rtl/cache_sim_pkg.sv - shared widths, set-state codes and controller FSM encoding for the cache simulator
package cache_sim_pkg;

  localparam int ADDR_W = 32;
  localparam int TAG_W  = 25;
  localparam int IDX_W  = 4;
  localparam int OFF_W  = 3;

  localparam logic STATE_SEARCH = 1'b0;
  localparam logic STATE_UPDATE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEARCH = 3'd1,
    ST_CHECK  = 3'd2,
    ST_UPDATE = 3'd3,
    ST_RESP   = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/cache_addr_decode.sv
// rtl/cache_addr_decode.sv - splits a reference address into tag, set index and one-hot set enable
module cache_addr_decode #(
  parameter int ADDR_W = cache_sim_pkg::ADDR_W,
  parameter int TAG_W  = cache_sim_pkg::TAG_W,
  parameter int IDX_W  = cache_sim_pkg::IDX_W,
  parameter int OFF_W  = cache_sim_pkg::OFF_W
) (
  input  logic [ADDR_W-1:0]      addr,
  output logic [TAG_W-1:0]       tag,
  output logic [IDX_W-1:0]       idx,
  output logic [(1<<IDX_W)-1:0]  onehot
);

  localparam int NUM_SETS = 1 << IDX_W;

  // Byte offset within a line never selects anything.
  logic unused_offset;

  assign unused_offset = ^addr[OFF_W-1:0];
  assign tag    = addr[ADDR_W-1:IDX_W+OFF_W];
  assign idx    = addr[IDX_W+OFF_W-1:OFF_W];
  assign onehot = {{(NUM_SETS-1){1'b0}}, 1'b1} << idx;

endmodule

// File: rtl/cache_access_ctrl.sv
// rtl/cache_access_ctrl.sv - sequences SEARCH/UPDATE on the cache sets per reference and keeps hit/miss statistics
module cache_access_ctrl #(
  parameter int ADDR_W = cache_sim_pkg::ADDR_W,
  parameter int TAG_W  = cache_sim_pkg::TAG_W,
  parameter int IDX_W  = cache_sim_pkg::IDX_W,
  parameter int OFF_W  = cache_sim_pkg::OFF_W,
  parameter int CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      req_addr,
  output logic [TAG_W-1:0]       set_tag,
  output logic [(1<<IDX_W)-1:0]  set_enable,
  output logic                   set_state,
  input  logic [(1<<IDX_W)-1:0]  set_hit,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_hit,
  output logic [ADDR_W-1:0]      resp_addr,
  input  logic                   clear_stats,
  output logic [CNT_W-1:0]       access_count,
  output logic [CNT_W-1:0]       hit_count,
  output logic [CNT_W-1:0]       miss_count
);

  import cache_sim_pkg::*;

  localparam int NUM_SETS = 1 << IDX_W;

  ctrl_state_t          state;
  logic [ADDR_W-1:0]    addr_q;
  logic                 hit_r;
  logic [NUM_SETS-1:0]  req_onehot;
  logic [NUM_SETS-1:0]  q_onehot;
  logic [IDX_W-1:0]     q_idx;
  logic [TAG_W-1:0]     unused_req_tag;
  logic [IDX_W-1:0]     unused_req_idx;
  logic                 resp_fire;

  // Incoming address decode lets set_enable be registered on the accept edge.
  cache_addr_decode #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .IDX_W(IDX_W), .OFF_W(OFF_W)) u_req_decode (
    .addr   (req_addr),
    .tag    (unused_req_tag),
    .idx    (unused_req_idx),
    .onehot (req_onehot)
  );

  cache_addr_decode #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .IDX_W(IDX_W), .OFF_W(OFF_W)) u_q_decode (
    .addr   (addr_q),
    .tag    (set_tag),
    .idx    (q_idx),
    .onehot (q_onehot)
  );

  assign resp_addr = addr_q;
  assign resp_fire = resp_valid & resp_ready;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      hit_r      <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      set_enable <= '0;
      set_state  <= STATE_UPDATE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            set_enable <= req_onehot;
            set_state  <= STATE_SEARCH;
            req_ready  <= 1'b0;
            state      <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          set_enable <= '0;
          set_state  <= STATE_UPDATE;
          state      <= ST_CHECK;
        end
        ST_CHECK: begin
          // Only the addressed set's hit is meaningful; a miss triggers the replacement update.
          hit_r      <= set_hit[q_idx];
          set_enable <= set_hit[q_idx] ? '0 : q_onehot;
          state      <= ST_UPDATE;
        end
        ST_UPDATE: begin
          set_enable <= '0;
          resp_valid <= 1'b1;
          resp_hit   <= hit_r;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          set_enable <= '0;
          set_state  <= STATE_UPDATE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      access_count <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
    end else if (clear_stats) begin
      access_count <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
    end else if (resp_fire) begin
      access_count <= sat_inc(access_count);
      if (resp_hit) hit_count <= sat_inc(hit_count);
      else          miss_count <= sat_inc(miss_count);
    end
  end

endmodule
